riscv_aes_ld: RTL and testbench
===============================

Name: riscv_aes_ld

Overview:
- Operand-fetch engine for the AES accelerator; the read-side counterpart of the AES result write-back unit.
- On a start pulse it halts the core and reads NUM_WORDS consecutive 32-bit words from data memory over the core's req/gnt/rvalid data port.
- It assembles the words into one block, presents it to the AES datapath with a one-cycle valid pulse, then releases the halt.

Parameters:
- NUM_WORDS, 4, number of 32-bit words fetched per block; block width is 32*NUM_WORDS; legal values 1..8.
- ADDR_STRIDE, 4, byte increment between consecutive word addresses.
- TIMEOUT_CYCLES, 64, watchdog limit; used only when RISCV_AES_LD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start_aes_ld  in  1  start pulse; sampled only in IDLE.
- address_in  in  32  byte address of word 0; bits [1:0] must be 0.
- data_req_o  out  1  memory read request.
- data_addr_o  out  32  memory word address.
- data_we_o  out  1  write enable; constant 0.
- data_be_o  out  4  byte enables; constant 4'b1111.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  read-data valid.
- data_rdata_i  in  32  read data.
- halt_en_out  out  1  core halt request.
- data_out  out  32*NUM_WORDS  assembled block.
- data_valid_out  out  1  one-cycle block-valid pulse.
- err_out  out  1  one-cycle error pulse.

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, cnt=0, cur_addr=0, data_out=0. data_req_o, halt_en_out, data_valid_out and err_out are all 0.
- Reset mid-operation: the block returns to IDLE immediately. data_req_o drops asynchronously. Partial data is discarded and no valid pulse is produced.
- States: IDLE, REQ, WAIT_RV, DONE. All outputs are registered or decoded from the registered state.
- IDLE:
  - On start_aes_ld=1: cur_addr<=address_in, cnt<=0, next state REQ.
  - address_in[1:0] is ignored (forced to 0 on data_addr_o).
- REQ:
  - data_req_o=1, data_addr_o=cur_addr.
  - The request stays asserted with a stable address until data_gnt_i=1.
  - On grant: next state WAIT_RV.
- WAIT_RV:
  - data_req_o=0; only one transaction is outstanding.
  - On data_rvalid_i=1: data_out[cnt*32+:32]<=data_rdata_i.
  - If cnt==NUM_WORDS-1, next state DONE.
  - Otherwise cnt<=cnt+1, cur_addr<=cur_addr+ADDR_STRIDE, next state REQ.
- DONE: data_valid_out=1 for exactly one cycle, then next state IDLE.
- halt_en_out = (state != IDLE). It goes high the cycle after start is sampled and stays high through the DONE cycle.
- Word order: the word at address_in+k*ADDR_STRIDE lands in data_out[32k+31:32k], little-endian word order, with no byte swap.
- data_out holds its value after DONE until overwritten by the next fetch. Words not yet refetched keep their old values until written.
- Address arithmetic is 32-bit modulo and wraps past 0xFFFFFFFC without error.
- Boundary rules:
  - rvalid outside WAIT_RV is ignored.
  - gnt outside REQ is ignored.
  - start while not IDLE is ignored; no queuing.
  - start in the same cycle as DONE is ignored.
- Latency: with gnt on first request and rvalid one cycle later, data_valid_out rises 2*NUM_WORDS+1 cycles after the start cycle (cycle 9 for NUM_WORDS=4).

Optional Feature:
- Macro: RISCV_AES_LD_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every entry to REQ or WAIT_RV and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES it drives the transition to DONE with err_out=1 and data_valid_out=0 in that cycle, and data_req_o drops.
  - data_out is left partially updated.
- Undefined: no counter exists, err_out is tied to 0, and the block waits indefinitely for gnt and rvalid.

Test Plan:
- Basic fetch:
  - Stimulus: reset, start with address_in=0x1000; memory grants immediately and returns rvalid next cycle with 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required: addresses 0x1000/0x1004/0x1008/0x100C; data_out=0x44444444_33333333_22222222_11111111; valid pulse at cycle 9; halt high cycles 1-9.
- Grant stall: hold data_gnt_i=0 for 5 cycles on word 2 -> data_req_o and data_addr_o=0x1008 held stable; valid delayed by exactly 5 cycles.
- Spurious events:
  - Pulse start and rvalid during REQ of word 1 -> both ignored.
  - Required: exactly 4 requests issued, data_out correct.
- Reset mid-fetch:
  - Assert rst_n=0 in WAIT_RV of word 2.
  - Required: data_req_o, halt_en_out and data_valid_out are 0 immediately; IDLE after release; the next start fetches normally.
- Wrap: address_in=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Timeout (macro defined, TIMEOUT_CYCLES=64):
  - Never assert rvalid for word 0.
  - Required: err_out pulses 1 cycle after 64 cycles in WAIT_RV, data_valid_out stays 0, halt drops the next cycle.

Source files
------------

// File: rtl/riscv_aes_ld.sv
// AES operand-fetch engine: halts the core, reads NUM_WORDS words over the data port, emits one block.
// Optional watchdog on stalled grant/rvalid enabled by defining RISCV_AES_LD_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start_aes_ld, core running
// REQ     | read request outstanding, waiting for grant
// WAIT_RV | granted, waiting for read data
// DONE    | block valid (or error) for one cycle
module riscv_aes_ld #(
  parameter int NUM_WORDS      = 4,
  parameter int ADDR_STRIDE    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_aes_ld,
  input  logic [31:0]               address_in,
  output logic                      data_req_o,
  output logic [31:0]               data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic [31:0]               data_rdata_i,
  output logic                      halt_en_out,
  output logic [32*NUM_WORDS-1:0]   data_out,
  output logic                      data_valid_out,
  output logic                      err_out
);

  localparam int BW = 32 * NUM_WORDS;
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  if (NUM_WORDS < 1 || NUM_WORDS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("riscv_aes_ld: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [BW-1:0]   data_q, data_d;

`ifdef RISCV_AES_LD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_aes_ld) begin
          addr_d  = {address_in[31:2], 2'b00};
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) state_d = WAIT_RV;
      end
      WAIT_RV: begin
        if (data_rvalid_i) begin
          data_d[int'(cnt_q)*32 +: 32] = data_rdata_i;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            addr_d  = addr_q + 32'(ADDR_STRIDE);
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef RISCV_AES_LD_TIMEOUT_EN
    err_d  = 1'b0;
    wdog_d = '0;
    // Any state change restarts the watchdog; only a stall with no progress can expire it.
    if ((state_q == REQ || state_q == WAIT_RV) && state_d == state_q) begin
      if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + WW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef RISCV_AES_LD_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef RISCV_AES_LD_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  assign data_req_o  = (state_q == REQ);
  assign data_addr_o = addr_q;
  assign data_we_o   = 1'b0;
  assign data_be_o   = 4'b1111;
  assign halt_en_out = (state_q != IDLE);
  assign data_out    = data_q;

`ifdef RISCV_AES_LD_TIMEOUT_EN
  assign data_valid_out = (state_q == DONE) && !err_q;
  assign err_out        = err_q;
`else
  assign data_valid_out = (state_q == DONE);
  assign err_out        = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_aes_ld.sv
// Scoreboard bench for riscv_aes_ld: expected addresses/blocks queued at start, checked as the DUT emits them.
module tb_riscv_aes_ld;

  localparam int NW = 4;
  localparam int BW = 32 * NW;

  logic          clk;
  logic          rst_n;
  logic          start_aes_ld;
  logic [31:0]   address_in;
  logic          data_req_o;
  logic [31:0]   data_addr_o;
  logic          data_we_o;
  logic [3:0]    data_be_o;
  logic          data_gnt_i;
  logic          data_rvalid_i;
  logic [31:0]   data_rdata_i;
  logic          halt_en_out;
  logic [BW-1:0] data_out;
  logic          data_valid_out;
  logic          err_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]   exp_addr_q[$];
  logic [BW-1:0] exp_blk_q[$];

  riscv_aes_ld #(.NUM_WORDS(NW), .ADDR_STRIDE(4), .TIMEOUT_CYCLES(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_aes_ld   (start_aes_ld),
    .address_in     (address_in),
    .data_req_o     (data_req_o),
    .data_addr_o    (data_addr_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i),
    .halt_en_out    (halt_en_out),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .err_out        (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  // Drives one fetch cycle by cycle; start cycle is 0, vcyc returns the cycle data_valid_out was seen.
  task automatic do_fetch(input logic [31:0] base, input logic [BW-1:0] words,
                          input int stall_word, input int stall_len, input bit spurious,
                          input int abort_word, input bit start_in_done, output int vcyc);
    int cyc, k, stall_left, nreq;
    bit rv_pend, in_req, halt_ok, err_seen, done, aborted;
    logic [31:0] held, mbase, ea;
    logic [BW-1:0] eb;
    vcyc = -1;
    mbase = {base[31:2], 2'b00};
    for (int i = 0; i < NW; i++) exp_addr_q.push_back(mbase + 32'(4 * i));
    if (abort_word < 0) exp_blk_q.push_back(words);
    @(negedge clk);
    start_aes_ld = 1'b1;
    address_in   = base;
    cyc = 0; k = 0; nreq = 0; stall_left = 0; held = '0;
    rv_pend = 0; in_req = 0; halt_ok = 1; err_seen = 0; done = 0; aborted = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_aes_ld  = 1'b0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = '0;
      if (halt_en_out !== 1'b1) halt_ok = 0;
      if (err_out !== 1'b0) err_seen = 1;
      if (rv_pend) begin
        rv_pend = 0;
        if (k - 1 == abort_word) begin
          rst_n = 1'b0;
          #1;
          n_checks++;
          if ({data_req_o, halt_en_out, data_valid_out} !== 3'b000)
            $display("FAIL reset_mid_outputs: req/halt/valid=%b required 000",
                     {data_req_o, halt_en_out, data_valid_out});
          else n_pass++;
          n_checks++;
          if (data_out !== '0) $display("FAIL reset_mid_data: data_out=%h required 0", data_out);
          else n_pass++;
          exp_addr_q.delete();
          done = 1;
          aborted = 1;
        end else begin
          data_rvalid_i = 1'b1;
          data_rdata_i  = words[32*(k-1) +: 32];
        end
      end else if (data_req_o === 1'b1) begin
        if (!in_req) begin
          in_req = 1;
          nreq++;
          stall_left = (k == stall_word) ? stall_len : 0;
          held = data_addr_o;
          ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
          n_checks++;
          if (data_addr_o !== ea) $display("FAIL req_addr w%0d: addr=%h required %h", k, data_addr_o, ea);
          else n_pass++;
          if (spurious && k == 1) begin
            stall_left    = 1;
            start_aes_ld  = 1'b1;
            data_rvalid_i = 1'b1;
            data_rdata_i  = 32'hDEAD_BEEF;
          end
        end else begin
          n_checks++;
          if (data_addr_o !== held) $display("FAIL stall_addr_stable: addr=%h required %h", data_addr_o, held);
          else n_pass++;
        end
        if (stall_left > 0) stall_left--;
        else begin
          data_gnt_i = 1'b1;
          in_req = 0;
          k++;
          rv_pend = 1;
        end
      end
      if (!aborted && data_valid_out === 1'b1) begin
        vcyc = cyc;
        done = 1;
        eb = (exp_blk_q.size() > 0) ? exp_blk_q.pop_front() : {BW{1'bx}};
        n_checks++;
        if (data_out !== eb) $display("FAIL block_data: data_out=%h required %h", data_out, eb);
        else n_pass++;
        if (start_in_done) begin
          start_aes_ld = 1'b1;
          address_in   = 32'h5000;
        end
      end
    end
    n_checks++;
    if (!done) $display("FAIL fetch_budget: no valid after %0d cycles required completion", cyc);
    else n_pass++;
    if (!aborted) begin
      n_checks++;
      if (nreq !== NW) $display("FAIL req_count: %0d requests required %0d", nreq, NW);
      else n_pass++;
      n_checks++;
      if (!halt_ok) $display("FAIL halt_during_fetch: halt dropped required high through DONE");
      else n_pass++;
      n_checks++;
      if (err_seen) $display("FAIL err_idle: err_out pulsed required 0");
      else n_pass++;
      @(negedge clk);
      start_aes_ld = 1'b0;
      n_checks++;
      if ({halt_en_out, data_valid_out, data_req_o} !== 3'b000)
        $display("FAIL post_done: halt/valid/req=%b required 000",
                 {halt_en_out, data_valid_out, data_req_o});
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data_req_o, halt_en_out, data_valid_out, err_out} !== 4'b0000)
      $display("FAIL reset_ctrl: req/halt/valid/err=%b required 0000",
               {data_req_o, halt_en_out, data_valid_out, err_out});
    else n_pass++;
    n_checks++;
    if (data_out !== '0) $display("FAIL reset_data: data_out=%h required 0", data_out);
    else n_pass++;
    n_checks++;
    if ({data_we_o, data_be_o, data_addr_o} !== {1'b0, 4'hF, 32'h0})
      $display("FAIL reset_port_consts: we=%b be=%h addr=%h required 0 f 0", data_we_o, data_be_o, data_addr_o);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int v;
    do_fetch(32'h1000, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, -1, 0, 0, -1, 0, v);
    n_checks++;
    if (v !== 2*NW + 1) $display("FAIL basic_latency: valid at %0d required %0d", v, 2*NW + 1);
    else n_pass++;
  endtask

  task automatic test_gnt_stall();
    int v;
    do_fetch(32'h1000, {$urandom, $urandom, $urandom, $urandom}, 2, 5, 0, -1, 0, v);
    n_checks++;
    if (v !== 2*NW + 1 + 5) $display("FAIL stall_latency: valid at %0d required %0d", v, 2*NW + 6);
    else n_pass++;
  endtask

  task automatic test_spurious();
    int v;
    do_fetch(32'h1200, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 1, -1, 0, v);
    n_checks++;
    if (v !== 2*NW + 2) $display("FAIL spurious_latency: valid at %0d required %0d", v, 2*NW + 2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int v;
    do_fetch(32'h1400, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 0, 2, 0, v);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({halt_en_out, data_req_o, data_valid_out} !== 3'b000)
      $display("FAIL reset_release_idle: halt/req/valid=%b required 000",
               {halt_en_out, data_req_o, data_valid_out});
    else n_pass++;
    do_fetch(32'h1400, {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3}, -1, 0, 0, -1, 0, v);
    n_checks++;
    if (v !== 2*NW + 1) $display("FAIL reset_refetch_latency: valid at %0d required %0d", v, 2*NW + 1);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int v;
    do_fetch(32'hFFFF_FFF8, {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8}, -1, 0, 0, -1, 0, v);
  endtask

  task automatic test_back_to_back();
    int v;
    do_fetch(32'h3003, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 0, -1, 1, v);
    do_fetch(32'h3100, {$urandom, $urandom, $urandom, $urandom}, 1, 2, 0, -1, 0, v);
    n_checks++;
    if (v !== 2*NW + 3) $display("FAIL b2b_latency: valid at %0d required %0d", v, 2*NW + 3);
    else n_pass++;
  endtask

`ifdef RISCV_AES_LD_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, ecyc;
    bit vseen;
    ecyc = -1; vseen = 0;
    @(negedge clk);
    start_aes_ld = 1'b1;
    address_in   = 32'h6000;
    cyc = 0;
    while (ecyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start_aes_ld = 1'b0;
      data_gnt_i   = data_req_o;
      if (data_valid_out === 1'b1) vseen = 1;
      if (err_out === 1'b1) ecyc = cyc;
    end
    data_gnt_i = 1'b0;
    n_checks++;
    if (ecyc !== 66) $display("FAIL timeout_err_cycle: err at %0d required 66", ecyc);
    else n_pass++;
    n_checks++;
    if (vseen) $display("FAIL timeout_valid: valid pulsed required 0");
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({halt_en_out, err_out} !== 2'b00)
      $display("FAIL timeout_halt_release: halt/err=%b required 00", {halt_en_out, err_out});
    else n_pass++;
  endtask
`endif

  initial begin
    start_aes_ld  = 1'b0;
    address_in    = '0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    rst_n         = 1'b0;
    test_reset();
    test_basic();
    test_gnt_stall();
    test_spurious();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
`ifdef RISCV_AES_LD_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
